// File: rtl/ss_map_pkg.sv
// Shared definitions for the map-swap initiator.
// Holds the transfer state encoding, the map-index type and the default
// edge locations and map count used by ss_map_transition_ctrl.
package ss_map_pkg;

    typedef enum logic [1:0] {
        RUN,
        REQ_NEXT,
        REQ_PREV,
        SETTLE
    } ss_xfer_state_t;

    typedef logic [1:0] ss_map_idx_t;

    localparam logic [7:0] SS_MIN_X_DEF    = 8'h01;
    localparam logic [7:0] SS_MAX_X_DEF    = 8'h7C;
    localparam int unsigned SS_NUM_MAPS_DEF = 3;

endpackage

// File: rtl/ss_ack_timer.sv
// Loadable down-counter used as the map_ack handshake timeout.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   start       - load LOAD and begin counting down (one count per cycle)
//   clear       - stop and idle the counter (has priority over start)
//   expired     - high while running with the count at zero
module ss_ack_timer #(
    parameter int unsigned LOAD = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int unsigned W = $clog2(LOAD + 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (clear) begin
            cnt_d = '0;
            run_d = 1'b0;
        end else if (start) begin
            cnt_d = W'(LOAD);
            run_d = 1'b1;
        end else if (run_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expired = run_q && (cnt_q == '0);

endmodule

// File: rtl/ss_map_transition_ctrl.sv
// Initiator side of the map-swap interface.
// Steps the horizontal world-map location on frame ticks and, at a screen
// edge with an adjacent map, requests a swap over a req/ack handshake, then
// teleports the location to the opposite edge.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   tick            - one-cycle frame strobe qualifying movement
//   move_right/left - level movement requests
//   blocked         - collision veto for this tick
//   map_ack         - responder has switched to map_req_idx
//   loc_x           - current location (MIN_X..MAX_X)
//   map_sel         - committed map index
//   map_req         - swap request, held until ack or timeout
//   map_req_idx     - requested map index
//   busy            - high outside RUN
//   xfer_err        - sticky handshake-timeout flag
module ss_map_transition_ctrl
    import ss_map_pkg::*;
#(
    parameter logic [7:0]  MIN_X       = SS_MIN_X_DEF,
    parameter logic [7:0]  MAX_X       = SS_MAX_X_DEF,
    parameter int unsigned NUM_MAPS    = SS_NUM_MAPS_DEF,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        move_right,
    input  logic        move_left,
    input  logic        blocked,
    input  logic        map_ack,
    output logic [7:0]  loc_x,
    output logic [1:0]  map_sel,
    output logic        map_req,
    output logic [1:0]  map_req_idx,
    output logic        busy,
    output logic        xfer_err
);

    localparam ss_map_idx_t LAST_MAP = ss_map_idx_t'(NUM_MAPS - 1);

    ss_xfer_state_t state_q, state_d;
    logic [7:0]     loc_x_q, loc_x_d;
    ss_map_idx_t    map_sel_q, map_sel_d;
    ss_map_idx_t    map_req_idx_q, map_req_idx_d;
    logic           map_req_q, map_req_d;
    logic           busy_q, busy_d;
    logic           xfer_err_q, xfer_err_d;

    logic go_right, go_left;
    logic tmr_start, tmr_clear, tmr_expired;

    // Timer is loaded on the REQ entry edge; counting ACK_TIMEOUT down to
    // zero keeps the request up for ACK_TIMEOUT+1 cycles.
    ss_ack_timer #(
        .LOAD (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (tmr_start),
        .clear   (tmr_clear),
        .expired (tmr_expired)
    );

    always_comb begin
        go_right = tick && !blocked && move_right && !move_left;
        go_left  = tick && !blocked && move_left  && !move_right;
    end

    always_comb begin
        state_d       = state_q;
        loc_x_d       = loc_x_q;
        map_sel_d     = map_sel_q;
        map_req_idx_d = map_req_idx_q;
        xfer_err_d    = xfer_err_q;
        tmr_start     = 1'b0;
        tmr_clear     = 1'b0;

        unique case (state_q)
            RUN: begin
                if (go_right) begin
                    if (loc_x_q < MAX_X) begin
                        loc_x_d = loc_x_q + 8'd1;
                    end else if (map_sel_q < LAST_MAP) begin
                        state_d       = REQ_NEXT;
                        map_req_idx_d = map_sel_q + 2'd1;
                        tmr_start     = 1'b1;
                    end
                end else if (go_left) begin
                    if (loc_x_q > MIN_X) begin
                        loc_x_d = loc_x_q - 8'd1;
                    end else if (map_sel_q != 2'd0) begin
                        state_d       = REQ_PREV;
                        map_req_idx_d = map_sel_q - 2'd1;
                        tmr_start     = 1'b1;
                    end
                end
            end
            REQ_NEXT, REQ_PREV: begin
                // Ack wins over a timeout expiring in the same cycle.
                if (map_ack) begin
                    map_sel_d = map_req_idx_q;
                    loc_x_d   = (state_q == REQ_NEXT) ? MIN_X : MAX_X;
                    state_d   = SETTLE;
                    tmr_clear = 1'b1;
                end else if (tmr_expired) begin
                    xfer_err_d = 1'b1;
                    state_d    = SETTLE;
                    tmr_clear  = 1'b1;
                end
            end
            SETTLE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        map_req_d = (state_d == REQ_NEXT) || (state_d == REQ_PREV);
        busy_d    = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            loc_x_q       <= MIN_X;
            map_sel_q     <= '0;
            map_req_idx_q <= '0;
            map_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            xfer_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            loc_x_q       <= loc_x_d;
            map_sel_q     <= map_sel_d;
            map_req_idx_q <= map_req_idx_d;
            map_req_q     <= map_req_d;
            busy_q        <= busy_d;
            xfer_err_q    <= xfer_err_d;
        end
    end

    assign loc_x       = loc_x_q;
    assign map_sel     = map_sel_q;
    assign map_req     = map_req_q;
    assign map_req_idx = map_req_idx_q;
    assign busy        = busy_q;
    assign xfer_err    = xfer_err_q;

endmodule

// File: doc/ss_map_transition_ctrl.md
# ss_map_transition_ctrl

Initiator side of the map-swap interface. Tracks the player's horizontal world-map location, steps it on frame ticks from movement commands, and at either screen edge requests a swap to the adjacent map over a req/ack handshake. It then teleports the location to the opposite edge. Sits between the movement/collision logic and the map muxer, which consumes `loc_x` and `map_sel` and acknowledges swap requests.

## Interface
Parameters:
- `MIN_X`, 8'h01: left-edge location.
- `MAX_X`, 8'h7C: right-edge location.
- `NUM_MAPS`, 3: number of maps in sequence; valid indices are 0..NUM_MAPS-1.
- `ACK_TIMEOUT`, 16: cycles to wait for `map_ack` before aborting.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `tick`  in  1  one-cycle frame strobe; movement is evaluated only on `tick`.
- `move_right`  in  1  level, player requests +X.
- `move_left`  in  1  level, player requests −X.
- `blocked`  in  1  collision: the move in the requested direction is forbidden this tick.
- `map_ack`  in  1  responder has switched to `map_req_idx`.
- `loc_x`  out  8  current location, always in MIN_X..MAX_X.
- `map_sel`  out  2  currently committed map index.
- `map_req`  out  1  swap request, held until ack or timeout.
- `map_req_idx`  out  2  requested map index, stable while `map_req`=1.
- `busy`  out  1  high in any state other than RUN.
- `xfer_err`  out  1  sticky; set on handshake timeout, cleared only by reset.

## Operation
- Reset values: `loc_x`=MIN_X, `map_sel`=0, `map_req`=0, `map_req_idx`=0, `busy`=0, `xfer_err`=0, state RUN.
- The direction is decoded on `tick`:
  - If exactly one of `move_right`/`move_left` is high, that is the direction.
  - If both or neither are high, there is no motion.
- RUN, on `tick` with a direction and `blocked`=0:
  - right, `loc_x`<MAX_X: `loc_x`+1.
  - left, `loc_x`>MIN_X: `loc_x`−1.
  - right, `loc_x`=MAX_X, `map_sel`<NUM_MAPS−1: go to REQ_NEXT, `map_req_idx`=`map_sel`+1.
  - left, `loc_x`=MIN_X, `map_sel`>0: go to REQ_PREV, `map_req_idx`=`map_sel`−1.
  - At an edge with no adjacent map, the location saturates and nothing else happens.
- `blocked`=1 on a tick means no motion and no swap request.
- REQ_NEXT/REQ_PREV:
  - `map_req`=1 while in these states; ticks are ignored.
  - On `map_ack`=1: `map_sel`<=`map_req_idx`; `loc_x`<=MIN_X for next, MAX_X for prev; `map_req`<=0; go to SETTLE.
  - If the timer reaches ACK_TIMEOUT with no ack: `map_req`<=0, `xfer_err`<=1, `map_sel` and `loc_x` unchanged, go to SETTLE.
- SETTLE lasts exactly one cycle and returns to RUN. It guarantees `map_req` is low for at least one cycle between requests.
- `map_ack` seen outside REQ_* is ignored.
- Arithmetic is unsigned 8-bit. Increment and decrement are only applied inside the bounds, so there is no wrap.
- Reset mid-handshake drops `map_req` asynchronously and restores all reset values.

## Timing
- All outputs are registered.
- A qualifying `tick` in cycle N produces the updated `loc_x` (or `map_req`=1) in cycle N+1.
- When `map_ack` is sampled high in cycle M:
  - `map_req`=0 and the new `map_sel`/`loc_x` appear in M+1.
  - `busy` falls in M+2, after SETTLE.
- `map_ack` may be high in the same cycle `map_req` first rises; it is accepted.
- Timeout: if `map_req` rises in cycle R with no ack, it is deasserted in R+ACK_TIMEOUT+1 and `xfer_err` rises in that same cycle.

## Structure
- Shared package `ss_map_pkg` holds:
  - the `ss_xfer_state_t` enum {RUN, REQ_NEXT, REQ_PREV, SETTLE};
  - the MIN_X/MAX_X/NUM_MAPS defaults;
  - the map-index typedef `ss_map_idx_t` (logic [1:0]).
- Sub-module `ss_ack_timer`: a loadable down-counter with `start`, `clear` and `expired`, sized to $clog2(ACK_TIMEOUT+1). It is instantiated once for the handshake timeout.

## Test plan
- Reset, then 5 ticks with `move_right`=1, `blocked`=0 → `loc_x` steps 01→06, one per tick; `map_sel`=0.
- Drive to `loc_x`=7C, then one more right tick → `map_req`=1 with `map_req_idx`=1; ack 3 cycles later → next cycle `loc_x`=01, `map_sel`=1, `map_req`=0; `busy` low one cycle after that.
- With `map_sel`=1 and `loc_x`=01, left tick → `map_req_idx`=0; ack → `loc_x`=7C, `map_sel`=0. With `map_sel`=2, right tick at 7C → no request, `loc_x` stays 7C.
- Request with no ack → `map_req` drops after 16+1 cycles, `xfer_err`=1, `loc_x`/`map_sel` unchanged. Ticks during REQ_* → `loc_x` unchanged. Both move inputs high, or `blocked`=1 → no change.
- Assert `reset` while `map_req`=1 → `map_req` low immediately (before the next edge), `loc_x`=01, `map_sel`=0, `xfer_err`=0; late ack after reset ignored.
